// File: rtl/wakeup_matrix_mp_if.sv
// Bus bundle for wakeup_matrix_mp: dispatch, grant, wakeup, cancel,
// retire and flush inputs plus the free-finder and request outputs.
// The master side drives the control inputs; the slave side is the matrix.
interface wakeup_matrix_mp_if #(
  parameter int RS_ENTRIES   = 16,
  parameter int NUM_FUS      = 4,
  parameter int DISP_WIDTH   = 2,
  parameter int ISSUE_WIDTH  = 2,
  parameter int RETIRE_WIDTH = 2
);
  localparam int COLS  = RS_ENTRIES * NUM_FUS;
  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic                            flush;
  logic [DISP_WIDTH-1:0]           disp_valid;
  logic [DISP_WIDTH*COLS-1:0]      disp_dep_mask;
  logic [DISP_WIDTH*IDX_W-1:0]     disp_entry;
  logic [DISP_WIDTH-1:0]           disp_ready;
  logic [IDX_W:0]                  free_count;
  logic [RS_ENTRIES-1:0]           reqs;
  logic [RS_ENTRIES-1:0]           oldest_req;
  logic [ISSUE_WIDTH-1:0]          grant_valid;
  logic [ISSUE_WIDTH*IDX_W-1:0]    grant_idx;
  logic [COLS-1:0]                 ready_mask;
  logic                            cancel_valid;
  logic [IDX_W-1:0]                cancel_entry;
  logic [RETIRE_WIDTH-1:0]         retire_valid;
  logic [RETIRE_WIDTH*IDX_W-1:0]   retire_entry;

  modport master (
    output flush, disp_valid, disp_dep_mask, grant_valid, grant_idx,
           ready_mask, cancel_valid, cancel_entry, retire_valid, retire_entry,
    input  disp_entry, disp_ready, free_count, reqs, oldest_req
  );

  modport slave (
    input  flush, disp_valid, disp_dep_mask, grant_valid, grant_idx,
           ready_mask, cancel_valid, cancel_entry, retire_valid, retire_entry,
    output disp_entry, disp_ready, free_count, reqs, oldest_req
  );
endinterface

// File: rtl/wakeup_matrix_mp.sv
// Multi-port reservation-station wakeup matrix. Each entry holds a
// dependency row over all FU columns; an entry requests select once it is
// valid, not granted and its row has drained to zero.
// Optional age ordering (oldest_req) is enabled with WAKEUP_AGE_ORDER_EN.
module wakeup_matrix_mp #(
  parameter int RS_ENTRIES   = 16,
  parameter int NUM_FUS      = 4,
  parameter int DISP_WIDTH   = 2,
  parameter int ISSUE_WIDTH  = 2,
  parameter int RETIRE_WIDTH = 2
) (
  input logic               clk,
  input logic               rst,
  wakeup_matrix_mp_if.slave bus
);
  localparam int COLS  = RS_ENTRIES * NUM_FUS;
  localparam int IDX_W = $clog2(RS_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_ENTRIES-1:0] valid_q;
  logic [RS_ENTRIES-1:0] granted_q;
  logic [COLS-1:0]       dep_q [RS_ENTRIES];

  logic [IDX_W-1:0]      sel [DISP_WIDTH];
  logic [CNT_W-1:0]      free_cnt;
  logic [DISP_WIDTH-1:0] slot_ready;
  logic [DISP_WIDTH-1:0] accept;
  logic [RS_ENTRIES-1:0] disp_hit;
  logic [RS_ENTRIES-1:0] retire_hit;
  logic [RS_ENTRIES-1:0] cancel_hit;
  logic [RS_ENTRIES-1:0] grant_hit;
  logic [RS_ENTRIES-1:0] reqs;
  logic [COLS-1:0]       row_next [RS_ENTRIES];

  // Free finder: slot k takes the (k+1)-th lowest invalid entry.
  always_comb begin
    free_cnt = '0;
    for (int k = 0; k < DISP_WIDTH; k++) sel[k] = IDX_W'(k);
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!valid_q[i]) begin
        for (int k = 0; k < DISP_WIDTH; k++) begin
          if (free_cnt == CNT_W'(k)) sel[k] = IDX_W'(i);
        end
        free_cnt = free_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < DISP_WIDTH; k++) begin : g_slot
    assign slot_ready[k] = free_cnt > CNT_W'(k);
    assign bus.disp_entry[k*IDX_W +: IDX_W] = sel[k];
  end

  assign accept         = bus.disp_valid & slot_ready & {DISP_WIDTH{~bus.flush}};
  assign bus.disp_ready = slot_ready;
  assign bus.free_count = free_cnt;

  // Per-entry decode of dispatch/retire/cancel/grant and next dependency row.
  // A dispatched row takes its mask minus this cycle's wakeups so a producer
  // completing in the dispatch cycle is not missed.
  always_comb begin
    disp_hit   = '0;
    retire_hit = '0;
    cancel_hit = '0;
    grant_hit  = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      row_next[i] = dep_q[i] & ~bus.ready_mask;
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (accept[k] && sel[k] == IDX_W'(i)) begin
          disp_hit[i] = 1'b1;
          row_next[i] = bus.disp_dep_mask[k*COLS +: COLS] & ~bus.ready_mask;
        end
      end
      for (int r = 0; r < RETIRE_WIDTH; r++) begin
        if (bus.retire_valid[r] && bus.retire_entry[r*IDX_W +: IDX_W] == IDX_W'(i))
          retire_hit[i] = 1'b1;
      end
      for (int g = 0; g < ISSUE_WIDTH; g++) begin
        if (bus.grant_valid[g] && bus.grant_idx[g*IDX_W +: IDX_W] == IDX_W'(i))
          grant_hit[i] = 1'b1;
      end
      cancel_hit[i] = bus.cancel_valid && (bus.cancel_entry == IDX_W'(i));
    end
  end

  // Entry state update. Dispatch only ever targets an entry that is invalid
  // in the registers, so it cannot collide with a meaningful retire/cancel/grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      granted_q <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) dep_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        dep_q[i] <= row_next[i];
        if (bus.flush) begin
          valid_q[i]   <= 1'b0;
          granted_q[i] <= 1'b0;
        end else if (disp_hit[i]) begin
          valid_q[i]   <= 1'b1;
          granted_q[i] <= 1'b0;
        end else if (retire_hit[i]) begin
          valid_q[i]   <= 1'b0;
          granted_q[i] <= 1'b0;
        end else if (cancel_hit[i] && valid_q[i]) begin
          granted_q[i] <= 1'b0;
        end else if (grant_hit[i] && valid_q[i]) begin
          granted_q[i] <= 1'b1;
        end
      end
    end
  end

  // Request vector straight from registered state.
  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++)
      reqs[i] = valid_q[i] & ~granted_q[i] & ~|dep_q[i];
  end

  assign bus.reqs = reqs;

`ifdef WAKEUP_AGE_ORDER_EN
  // age_q[i][j] = 1 means entry i is older than entry j.
  logic [RS_ENTRIES-1:0] age_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0] older [DISP_WIDTH];
  logic [RS_ENTRIES-1:0] seen;
  logic [RS_ENTRIES-1:0] col;
  logic [RS_ENTRIES-1:0] oldest;

  // Entries older than each slot's new entry: everything already valid plus
  // lower slots accepted in the same cycle.
  always_comb begin
    seen = valid_q;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      older[k] = seen;
      if (accept[k]) seen[sel[k]] = 1'b1;
    end
  end

  // Row clears first, then column writes, so a same-cycle higher slot
  // still records the lower slot as older.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_ENTRIES; i++) age_q[i] <= '0;
    end else begin
      for (int k = 0; k < DISP_WIDTH; k++)
        if (accept[k]) age_q[sel[k]] <= '0;
      for (int k = 0; k < DISP_WIDTH; k++)
        if (accept[k])
          for (int j = 0; j < RS_ENTRIES; j++) age_q[j][sel[k]] <= older[k][j];
    end
  end

  // A requester is oldest when no other requester is older than it.
  always_comb begin
    col    = '0;
    oldest = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      for (int j = 0; j < RS_ENTRIES; j++) col[j] = age_q[j][i];
      oldest[i] = reqs[i] & ~|(reqs & col);
    end
  end

  assign bus.oldest_req = oldest;
`else
  assign bus.oldest_req = '0;
`endif

endmodule

// File: tb/tb_wakeup_matrix_mp.sv
// Self-checking bench for wakeup_matrix_mp: a timestamp-based entry model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_wakeup_matrix_mp;
  localparam int N     = 16;
  localparam int COLS  = 64;
  localparam int IW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wakeup_matrix_mp_if bus_if ();

  wakeup_matrix_mp dut (.clk(clk), .rst(rst), .bus(bus_if));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // ---------------- model ----------------
  bit          m_valid   [N];
  bit          m_granted [N];
  logic [63:0] m_dep     [N];
  int          m_stamp   [N];
  int          stamp_ctr = 0;
  bit          f_ret [N];
  bit          f_can [N];
  bit          f_gnt [N];

  function automatic int m_free_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (!m_valid[i]) c++;
    return c;
  endfunction

  function automatic int m_free_nth(int k);
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_valid[i]) begin
        if (c == k) return i;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic logic [15:0] m_reqs();
    logic [15:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_valid[i] && !m_granted[i] && (m_dep[i] == 64'd0);
    return r;
  endfunction

  function automatic logic [15:0] m_oldest();
    logic [15:0] o = '0;
`ifdef WAKEUP_AGE_ORDER_EN
    logic [15:0] r = m_reqs();
    int best = -1;
    for (int i = 0; i < N; i++)
      if (r[i] && (best < 0 || m_stamp[i] < m_stamp[best])) best = i;
    if (best >= 0) o[best] = 1'b1;
`endif
    return o;
  endfunction

  always @(posedge clk) begin : model
    int ent [2];
    bit acc [2];
    int nfree;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_granted[i] = 0; m_dep[i] = '0;
      end
    end else if (bus_if.flush) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0; m_granted[i] = 0;
      end
    end else begin
      nfree = m_free_count();
      for (int k = 0; k < 2; k++) begin
        acc[k] = bus_if.disp_valid[k] && (nfree > k);
        ent[k] = m_free_nth(k);
      end
      for (int i = 0; i < N; i++) begin
        f_ret[i] = 0; f_can[i] = 0; f_gnt[i] = 0;
      end
      for (int r = 0; r < 2; r++)
        if (bus_if.retire_valid[r]) f_ret[bus_if.retire_entry[r*IW +: IW]] = 1;
      for (int g = 0; g < 2; g++)
        if (bus_if.grant_valid[g]) f_gnt[bus_if.grant_idx[g*IW +: IW]] = 1;
      if (bus_if.cancel_valid) f_can[bus_if.cancel_entry] = 1;
      for (int i = 0; i < N; i++) begin
        m_dep[i] = m_dep[i] & ~bus_if.ready_mask;
        if (f_ret[i]) begin
          m_valid[i] = 0; m_granted[i] = 0;
        end else if (f_can[i] && m_valid[i]) m_granted[i] = 0;
        else if (f_gnt[i] && m_valid[i]) m_granted[i] = 1;
      end
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          m_valid[ent[k]]   = 1;
          m_granted[ent[k]] = 0;
          m_dep[ent[k]]     = bus_if.disp_dep_mask[k*COLS +: COLS] & ~bus_if.ready_mask;
          m_stamp[ent[k]]   = stamp_ctr;
          stamp_ctr++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int nf;
      nf = m_free_count();
      n_checks++;
      if (bus_if.reqs !== m_reqs()) begin
        n_fail++;
        $display("FAIL reqs t=%0t actual=%h required=%h", $time, bus_if.reqs, m_reqs());
      end
      n_checks++;
      if (bus_if.oldest_req !== m_oldest()) begin
        n_fail++;
        $display("FAIL oldest_req t=%0t actual=%h required=%h", $time, bus_if.oldest_req, m_oldest());
      end
      n_checks++;
      if (bus_if.free_count !== 5'(nf)) begin
        n_fail++;
        $display("FAIL free_count t=%0t actual=%0d required=%0d", $time, bus_if.free_count, nf);
      end
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (bus_if.disp_ready[k] !== (nf > k)) begin
          n_fail++;
          $display("FAIL disp_ready[%0d] t=%0t actual=%b required=%b", k, $time, bus_if.disp_ready[k], nf > k);
        end
        if (nf > k) begin
          n_checks++;
          if (bus_if.disp_entry[k*IW +: IW] !== 4'(m_free_nth(k))) begin
            n_fail++;
            $display("FAIL disp_entry[%0d] t=%0t actual=%0d required=%0d", k, $time,
                     bus_if.disp_entry[k*IW +: IW], m_free_nth(k));
          end
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus_if.flush         = 1'b0;
    bus_if.disp_valid    = '0;
    bus_if.disp_dep_mask = '0;
    bus_if.grant_valid   = '0;
    bus_if.grant_idx     = '0;
    bus_if.ready_mask    = '0;
    bus_if.cancel_valid  = 1'b0;
    bus_if.cancel_entry  = '0;
    bus_if.retire_valid  = '0;
    bus_if.retire_entry  = '0;
  endtask

  // Apply currently driven inputs for one clock edge, then return to idle.
  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  localparam logic [15:0] OLD_B = `ifdef WAKEUP_AGE_ORDER_EN 16'h0002 `else 16'h0000 `endif;
  localparam logic [15:0] OLD_A = `ifdef WAKEUP_AGE_ORDER_EN 16'h0001 `else 16'h0000 `endif;

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    lit("rst_reqs", 64'(bus_if.reqs), 64'h0);
    lit("rst_oldest", 64'(bus_if.oldest_req), 64'h0);
    lit("rst_free", 64'(bus_if.free_count), 64'd16);
    lit("rst_ready", 64'(bus_if.disp_ready), 64'h3);
    lit("rst_entry", 64'(bus_if.disp_entry), 64'h10);

    // Two clear dispatches
    bus_if.disp_valid = 2'b11;
    tick();
    lit("dual_free", 64'(bus_if.free_count), 64'd14);
    lit("dual_reqs", 64'(bus_if.reqs), 64'h3);
    lit("dual_entry", 64'(bus_if.disp_entry), 64'h32);
    bus_if.retire_valid = 2'b11; bus_if.retire_entry = 8'h10;
    tick();
    lit("retire01_free", 64'(bus_if.free_count), 64'd16);

    // Wakeup by column 5
    bus_if.disp_valid = 2'b01; bus_if.disp_dep_mask = 128'h20;
    tick();
    lit("dep5_c1", 64'(bus_if.reqs), 64'h0);
    tick();
    lit("dep5_c2", 64'(bus_if.reqs), 64'h0);
    bus_if.ready_mask = 64'h20;
    tick();
    lit("dep5_wake", 64'(bus_if.reqs), 64'h1);

    // Same-cycle bypass, grant, cancel
    bus_if.disp_valid = 2'b01; bus_if.disp_dep_mask = 128'h80; bus_if.ready_mask = 64'h80;
    tick();
    lit("bypass_reqs", 64'(bus_if.reqs), 64'h3);
    lit("two_old", 64'(bus_if.oldest_req), 64'(OLD_A));
    bus_if.grant_valid = 2'b11; bus_if.grant_idx = {4'd12, 4'd0};
    tick();
    lit("grant_reqs", 64'(bus_if.reqs), 64'h2);
    lit("grant_inv_free", 64'(bus_if.free_count), 64'd14);
    bus_if.cancel_valid = 1'b1; bus_if.cancel_entry = 4'd0;
    tick();
    lit("cancel_reqs", 64'(bus_if.reqs), 64'h3);
    bus_if.retire_valid = 2'b11; bus_if.retire_entry = 8'h10;
    tick();

    // Fill, overflow, retire two
    for (int c = 0; c < 8; c++) begin
      bus_if.disp_valid = 2'b11;
      tick();
    end
    lit("full_free", 64'(bus_if.free_count), 64'd0);
    lit("full_ready", 64'(bus_if.disp_ready), 64'h0);
    bus_if.disp_valid = 2'b11; bus_if.disp_dep_mask = {64'h1, 64'h1};
    tick();
    lit("full_drop_reqs", 64'(bus_if.reqs), 64'hFFFF);
    lit("full_drop_free", 64'(bus_if.free_count), 64'd0);
    bus_if.retire_valid = 2'b11; bus_if.retire_entry = {4'd9, 4'd3};
    tick();
    lit("ret39_entry", 64'(bus_if.disp_entry), 64'h93);
    lit("ret39_free", 64'(bus_if.free_count), 64'd2);

    // Grant 4, then retire+cancel 4 together
    bus_if.grant_valid = 2'b01; bus_if.grant_idx = 8'h04;
    tick();
    lit("g4_reqs", 64'(bus_if.reqs), 64'hFDE7);
    bus_if.retire_valid = 2'b01; bus_if.retire_entry = 8'h04;
    bus_if.cancel_valid = 1'b1; bus_if.cancel_entry = 4'd4;
    tick();
    lit("rc4_reqs", 64'(bus_if.reqs), 64'hFDE7);
    lit("rc4_free", 64'(bus_if.free_count), 64'd3);

    // Flush with dispatch pending
    bus_if.flush = 1'b1; bus_if.disp_valid = 2'b11;
    tick();
    lit("flush_reqs", 64'(bus_if.reqs), 64'h0);
    lit("flush_free", 64'(bus_if.free_count), 64'd16);
    tick();
    lit("flush_idle_reqs", 64'(bus_if.reqs), 64'h0);

    // Age ordering: A older, B wakes first
    bus_if.disp_valid = 2'b01; bus_if.disp_dep_mask = 128'h400;
    tick();
    bus_if.disp_valid = 2'b01; bus_if.disp_dep_mask = 128'h800;
    tick();
    bus_if.ready_mask = 64'h800;
    tick();
    lit("age_b_reqs", 64'(bus_if.reqs), 64'h2);
    lit("age_b_old", 64'(bus_if.oldest_req), 64'(OLD_B));
    bus_if.ready_mask = 64'h400;
    tick();
    lit("age_a_reqs", 64'(bus_if.reqs), 64'h3);
    lit("age_a_old", 64'(bus_if.oldest_req), 64'(OLD_A));

    // Mixed traffic checked by the model each cycle
    for (int c = 0; c < 400; c++) begin
      bus_if.disp_valid    = 2'($urandom);
      bus_if.disp_dep_mask = {56'h0, 8'($urandom & $urandom), 56'h0, 8'($urandom & $urandom)};
      bus_if.ready_mask    = 64'(8'($urandom));
      bus_if.grant_valid   = 2'($urandom);
      bus_if.grant_idx     = 8'($urandom);
      bus_if.cancel_valid  = ($urandom_range(0, 3) == 0);
      bus_if.cancel_entry  = 4'($urandom);
      bus_if.retire_valid  = 2'($urandom & $urandom);
      bus_if.retire_entry  = 8'($urandom);
      bus_if.flush         = ($urandom_range(0, 40) == 0);
      tick();
    end

    // Reset mid-operation
    bus_if.disp_valid = 2'b11;
    tick();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("rst2_reqs", 64'(bus_if.reqs), 64'h0);
    lit("rst2_free", 64'(bus_if.free_count), 64'd16);
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
